// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry response buffer per requester.
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int PRIO_RESET = 0
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [4:0]       r0_opcode,
    input  logic [4:0]       r0_shamt,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rvalid,
    input  logic             r0_rready,
    output logic [WIDTH-1:0] r0_result,
    output logic [2:0]       r0_flags,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [4:0]       r1_opcode,
    input  logic [4:0]       r1_shamt,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rvalid,
    input  logic             r1_rready,
    output logic [WIDTH-1:0] r1_result,
    output logic [2:0]       r1_flags,

    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [4:0]       alu_opcode,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ne,
    input  logic             alu_lt,
    input  logic             alu_ovf
);

    logic ptr;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // A full buffer that drains this cycle can take a new op.
    always_comb begin
        elig0  = r0_valid & (~r0_rvalid | r0_rready);
        elig1  = r1_valid & (~r1_rvalid | r1_rready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
                grant0 = ~ptr;
                grant1 = ptr;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    always_comb begin
        alu_opA    = '0;
        alu_opB    = '0;
        alu_opcode = '0;
        alu_shamt  = '0;
        if (grant0) begin
            alu_opA    = r0_a;
            alu_opB    = r0_b;
            alu_opcode = r0_opcode;
            alu_shamt  = r0_shamt;
        end else if (grant1) begin
            alu_opA    = r1_a;
            alu_opB    = r1_b;
            alu_opcode = r1_opcode;
            alu_shamt  = r1_shamt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= (PRIO_RESET != 0);
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

    // Accept overrides drain; a drain alone only clears valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r0_rvalid <= 1'b0;
            r0_result <= '0;
            r0_flags  <= '0;
        end else if (grant0) begin
            r0_rvalid <= 1'b1;
            r0_result <= alu_result;
            r0_flags  <= {alu_ovf, alu_lt, alu_ne};
        end else if (r0_rvalid && r0_rready) begin
            r0_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r1_rvalid <= 1'b0;
            r1_result <= '0;
            r1_flags  <= '0;
        end else if (grant1) begin
            r1_rvalid <= 1'b1;
            r1_result <= alu_result;
            r1_flags  <= {alu_ovf, alu_lt, alu_ne};
        end else if (r1_rvalid && r1_rready) begin
            r1_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a small behavioural ALU model.
module tb_alu_share_arbiter;

    localparam int W = 32;

    typedef struct {
        logic [4:0]   op;
        logic [4:0]   sh;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [34:0]  exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    logic r0_valid, r0_ready, r0_rvalid, r0_rready;
    logic r1_valid, r1_ready, r1_rvalid, r1_rready;
    logic [4:0] r0_opcode, r0_shamt, r1_opcode, r1_shamt;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b, r0_result, r1_result;
    logic [2:0] r0_flags, r1_flags;
    logic [W-1:0] alu_opA, alu_opB, alu_result;
    logic [4:0] alu_opcode, alu_shamt;
    logic alu_ne, alu_lt, alu_ovf;

    logic [34:0] exp0_cur, exp1_cur;
    logic [34:0] q0[$];
    logic [34:0] q1[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    alu_share_arbiter #(.WIDTH(W), .PRIO_RESET(0)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_opcode(r0_opcode), .r0_shamt(r0_shamt),
        .r0_a(r0_a), .r0_b(r0_b),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
        .r0_result(r0_result), .r0_flags(r0_flags),
        .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_opcode(r1_opcode), .r1_shamt(r1_shamt),
        .r1_a(r1_a), .r1_b(r1_b),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
        .r1_result(r1_result), .r1_flags(r1_flags),
        .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_ne(alu_ne),
        .alu_lt(alu_lt), .alu_ovf(alu_ovf)
    );

    // ALU model: compare flags come from the subtract path only.
    always_comb begin
        alu_result = '0;
        alu_ne     = 1'b0;
        alu_lt     = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_opcode)
            5'd0: begin
                alu_result = alu_opA + alu_opB;
                alu_ovf = (alu_opA[W-1] == alu_opB[W-1]) &&
                          (alu_result[W-1] != alu_opA[W-1]);
            end
            5'd1: begin
                alu_result = alu_opA - alu_opB;
                alu_ovf = (alu_opA[W-1] != alu_opB[W-1]) &&
                          (alu_result[W-1] != alu_opA[W-1]);
                alu_ne = (alu_opA != alu_opB);
                alu_lt = ($signed(alu_opA) < $signed(alu_opB));
            end
            5'd2: alu_result = alu_opA & alu_opB;
            5'd3: alu_result = alu_opA | alu_opB;
            5'd4: alu_result = alu_opA << alu_shamt;
            5'd5: alu_result = $signed(alu_opA) >>> alu_shamt;
            default: alu_result = '0;
        endcase
    end

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (r0_rvalid && r0_rready) begin
                if (q0.size() == 0) chk("r0 unexpected resp", 1, 0);
                else chk("r0 resp", {r0_flags, r0_result}, q0.pop_front());
            end
            if (r1_rvalid && r1_rready) begin
                if (q1.size() == 0) chk("r1 unexpected resp", 1, 0);
                else chk("r1 resp", {r1_flags, r1_result}, q1.pop_front());
            end
            if (r0_valid && r0_ready) q0.push_back(exp0_cur);
            if (r1_valid && r1_ready) q1.push_back(exp1_cur);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input vec_t v);
        r0_opcode = v.op; r0_shamt = v.sh;
        r0_a = v.a; r0_b = v.b; exp0_cur = v.exp;
    endtask

    task automatic drive1(input vec_t v);
        r1_opcode = v.op; r1_shamt = v.sh;
        r1_a = v.a; r1_b = v.b; exp1_cur = v.exp;
    endtask

    task automatic send(input bit req, input vec_t v);
        bit got = 1'b0;
        if (req) begin drive1(v); r1_valid = 1'b1; end
        else begin drive0(v); r0_valid = 1'b1; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = req ? r1_ready : r0_ready;
            step();
        end
        if (req) r1_valid = 1'b0;
        else r0_valid = 1'b0;
        chk("send handshake", {63'd0, got}, 64'd1);
    endtask

    vec_t v0[2];
    vec_t v1[2];
    vec_t v;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1;
        bit h0, h1;
        reset = 1'b1;
        r0_valid = 0; r1_valid = 0; r0_rready = 1; r1_rready = 1;
        v = '{5'd0, 5'd0, 32'd0, 32'd0, 35'd0};
        drive0(v); drive1(v);
        step(); step();
        @(negedge clock);
        chk("reset ready", {r1_ready, r0_ready}, 0);
        chk("reset rvalid", {r1_rvalid, r0_rvalid}, 0);
        chk("reset r0 data", {r0_flags, r0_result}, 0);
        chk("reset r1 data", {r1_flags, r1_result}, 0);
        step();
        reset = 1'b0;

        // 1: single add
        drive0('{5'd0, 5'd0, 32'd5, 32'd7, {3'b000, 32'd12}});
        r0_valid = 1'b1;
        @(negedge clock);
        chk("t1 r0_ready", r0_ready, 1);
        chk("t1 r1_ready", r1_ready, 0);
        chk("t1 alu_opA", alu_opA, 5);
        step();
        r0_valid = 1'b0;
        @(negedge clock);
        chk("t1 r0_rvalid", r0_rvalid, 1);
        chk("t1 r1 untouched", {r1_rvalid, r1_flags, r1_result}, 0);
        step();

        // 2: alternating grants from reset pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        v0[0] = '{5'd0, 5'd0, 32'd1, 32'd2, {3'b000, 32'd3}};
        v0[1] = '{5'd0, 5'd0, 32'd100, 32'd23, {3'b000, 32'd123}};
        v1[0] = '{5'd1, 5'd0, 32'd9, 32'd4, {3'b001, 32'd5}};
        v1[1] = '{5'd1, 5'd0, 32'd4, 32'd4, {3'b000, 32'd0}};
        i0 = 0; i1 = 0;
        drive0(v0[0]); drive1(v1[0]);
        r0_valid = 1; r1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("t2 grant", {r1_ready, r0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2 rvalid lag", {r1_rvalid, r0_rvalid},
                (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
            h0 = r0_ready; h1 = r1_ready;
            step();
            if (h0 && i0 < 1) begin i0++; drive0(v0[i0]); end
            if (h1 && i1 < 1) begin i1++; drive1(v1[i1]); end
        end
        r0_valid = 0; r1_valid = 0;
        @(negedge clock);
        chk("t2 last rvalid", {r1_rvalid, r0_rvalid}, 2'b10);
        step();

        // 3: sub flags and add overflow
        send(0, '{5'd1, 5'd0, 32'd3, 32'd5, {3'b011, 32'hFFFF_FFFE}});
        send(0, '{5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, {3'b100, 32'h8000_0000}});
        step();

        // 4: r1 blocked by a full buffer
        r1_rready = 0;
        send(1, '{5'd0, 5'd0, 32'd2, 32'd2, {3'b000, 32'd4}});
        drive0('{5'd0, 5'd0, 32'd1, 32'd1, {3'b000, 32'd2}});
        drive1('{5'd0, 5'd0, 32'd6, 32'd1, {3'b000, 32'd7}});
        r0_valid = 1; r1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t4 grant r0 only", {r1_ready, r0_ready}, 2'b01);
            chk("t4 r1 stable", {r1_rvalid, r1_result}, {1'b1, 32'd4});
            step();
        end
        r1_rready = 1;
        @(negedge clock);
        chk("t4 r1 granted", {r1_ready, r0_ready}, 2'b10);
        step();
        r0_valid = 0; r1_valid = 0;
        @(negedge clock);
        chk("t4 r1 rvalid", r1_rvalid, 1);
        step();

        // 5: reset mid-operation
        r0_rready = 0;
        send(0, '{5'd0, 5'd0, 32'd5, 32'd5, {3'b000, 32'd10}});
        reset = 1;
        drive1('{5'd0, 5'd0, 32'd8, 32'd8, {3'b000, 32'd16}});
        r1_valid = 1;
        @(negedge clock);
        chk("t5 no grant in reset", {r1_ready, r0_ready}, 0);
        step();
        reset = 0; r1_valid = 0; r0_rready = 1;
        @(negedge clock);
        chk("t5 rvalid cleared", {r1_rvalid, r0_rvalid}, 0);
        chk("t5 data cleared", {r0_result, r1_result}, 0);
        chk("t5 flags cleared", {r0_flags, r1_flags}, 0);
        step();
        drive0('{5'd0, 5'd0, 32'd3, 32'd4, {3'b000, 32'd7}});
        drive1('{5'd3, 5'd0, 32'hF0, 32'h0F, {3'b000, 32'hFF}});
        r0_valid = 1; r1_valid = 1;
        @(negedge clock);
        chk("t5 reset pointer", {r1_ready, r0_ready}, 2'b01);
        step();
        r0_valid = 0;
        @(negedge clock);
        chk("t5 then r1", {r1_ready, r0_ready}, 2'b10);
        step();
        r1_valid = 0;

        // 6: idle cycles and SLL via r1
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t6 idle alu", {alu_opA, alu_opcode, alu_shamt}, 0);
            chk("t6 idle alu_opB", alu_opB, 0);
            step();
        end
        drive0('{5'd2, 5'd0, 32'hFF, 32'h0F, {3'b000, 32'h0F}});
        drive1('{5'd4, 5'd31, 32'd1, 32'd0, {3'b000, 32'h8000_0000}});
        r0_valid = 1; r1_valid = 1;
        @(negedge clock);
        chk("t6 pointer held", {r1_ready, r0_ready}, 2'b01);
        step();
        r0_valid = 0;
        @(negedge clock);
        chk("t6 r1 granted", r1_ready, 1);
        chk("t6 alu drive r1", {alu_opcode, alu_shamt}, {5'd4, 5'd31});
        step();
        r1_valid = 0;
        step(); step();
        @(negedge clock);
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
